// File: rtl/sb_reg_file_pkg.sv
// sb_reg_file_pkg: shared defaults and the write-port payload for the register file.
package sb_reg_file_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 5;

   // One write port's worth of request at the default geometry.
   typedef struct packed {
      logic                      en;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } wr_port_t;

endpackage : sb_reg_file_pkg

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, issue acceptance and set/clear priority.
// Register 0 is never busy; an accepted issue wins over a same-cycle write clear.
module rf_scoreboard
   import sb_reg_file_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_WR     = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_WR-1:0]                    wr_en,
   input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr,
   input  logic                                 iss_en,
   input  logic [ADDR_WIDTH-1:0]                iss_addr,
   output logic [(1 << ADDR_WIDTH)-1:0]         busy,
   output logic                                 iss_ok
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0] wr_hit;
   logic [DEPTH-1:0] busy_nxt;

   // Decode active writes, decide issue acceptance and next busy state.
   always_comb begin
      wr_hit   = '0;
      busy_nxt = busy;
      for (int p = 0; p < int'(NUM_WR); p++) begin
         if (wr_en[p] && (wr_addr[p] != '0)) wr_hit[wr_addr[p]] = 1'b1;
      end
      iss_ok   = iss_en && ((iss_addr == '0) || !busy[iss_addr] || wr_hit[iss_addr]);
      busy_nxt = busy & ~wr_hit;
      if (iss_ok && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Busy bit register; reset clears every entry immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

endmodule : rf_scoreboard

// File: rtl/sb_reg_file.sv
// sb_reg_file: multi-port register file with issue scoreboard.
// Optional macro RF_BYPASS_EN forwards same-cycle write data (and a cleared
// busy bit) to the read ports; without it writes become visible next cycle.
module sb_reg_file
   import sb_reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_RD     = 2,
   parameter int unsigned NUM_WR     = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_WR-1:0]                    wr_en,
   input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr,
   input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data,
   input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr,
   output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data,
   output logic [NUM_RD-1:0]                    rd_busy,
   input  logic                                 iss_en,
   input  logic [ADDR_WIDTH-1:0]                iss_addr,
   output logic                                 iss_ok,
   output logic                                 wr_conflict
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic [DEPTH-1:0]                 busy;

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WR     (NUM_WR)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy     (busy),
      .iss_ok   (iss_ok)
   );

   // Data array; later ports overwrite earlier ones so the highest index wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '0;
      end else begin
         for (int p = 0; p < int'(NUM_WR); p++) begin
            if (wr_en[p] && (wr_addr[p] != '0)) mem[wr_addr[p]] <= wr_data[p];
         end
      end
   end

   // Flag two or more enabled ports hitting the same nonzero register.
   always_comb begin
      wr_conflict = 1'b0;
      for (int i = 0; i < int'(NUM_WR); i++) begin
         for (int j = i + 1; j < int'(NUM_WR); j++) begin
            if (wr_en[i] && wr_en[j] && (wr_addr[i] == wr_addr[j]) && (wr_addr[i] != '0))
               wr_conflict = !rst;
         end
      end
   end

   // Read muxing with optional same-cycle write forwarding.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int r = 0; r < int'(NUM_RD); r++) begin
         rd_data[r] = mem[rd_addr[r]];
         rd_busy[r] = busy[rd_addr[r]];
`ifdef RF_BYPASS_EN
         for (int p = 0; p < int'(NUM_WR); p++) begin
            if (!rst && wr_en[p] && (wr_addr[p] != '0) && (wr_addr[p] == rd_addr[r])) begin
               rd_data[r] = wr_data[p];
               rd_busy[r] = 1'b0;
            end
         end
`else
`endif
      end
   end

endmodule : sb_reg_file

// File: tb/tb_sb_reg_file.sv
// tb_sb_reg_file: directed self-checking bench for sb_reg_file (2 read, 2 write ports).
module tb_sb_reg_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0]            wr_en;
   logic [1:0][AW-1:0]    wr_addr;
   logic [1:0][DW-1:0]    wr_data;
   logic [1:0][AW-1:0]    rd_addr;
   logic [1:0][DW-1:0]    rd_data;
   logic [1:0]            rd_busy;
   logic                  iss_en;
   logic [AW-1:0]         iss_addr;
   logic                  iss_ok;
   logic                  wr_conflict;

   int vectors     = 0;
   int miscompares = 0;

   sb_reg_file #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_RD (2), .NUM_WR (2)
   ) dut (
      .clk (clk), .rst (rst),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
      .iss_en (iss_en), .iss_addr (iss_addr), .iss_ok (iss_ok),
      .wr_conflict (wr_conflict)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      rd_addr = '0;
      // activity during reset must be discarded
      wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'hAAAA_5555;
      iss_en = 1'b1; iss_addr = 5'd6;
      rd_addr[0] = 5'd4; rd_addr[1] = 5'd6;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (iss_ok !== 1'b1) begin miscompares++; $display("FAIL reset_iss_ok: got %b expected 1", iss_ok); end
      vectors++;
      if (wr_conflict !== 1'b0) begin miscompares++; $display("FAIL reset_conflict: got %b expected 0", wr_conflict); end
      vectors++;
      if (rd_data[0] !== 32'h0) begin miscompares++; $display("FAIL reset_rd4: got %h expected 0", rd_data[0]); end
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      for (int a = 0; a < 32; a++) begin
         rd_addr[0] = AW'(a);
         rd_addr[1] = AW'(31 - a);
         #1;
         vectors++;
         if (rd_data !== '0 || rd_busy !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_read a=%0d: got data %h busy %b expected 0 / 00", a, rd_data, rd_busy);
         end
      end
   endtask

   task automatic test_conflict();
      @(negedge clk);
      wr_en = 2'b11;
      wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
      wr_addr[1] = 5'd5; wr_data[1] = 32'h1234_5678;
      rd_addr[0] = 5'd5;
      #1;
      vectors++;
      if (wr_conflict !== 1'b1) begin miscompares++; $display("FAIL conflict_flag: got %b expected 1", wr_conflict); end
`ifdef RF_BYPASS_EN
      vectors++;
      if (rd_data[0] !== 32'h1234_5678) begin miscompares++; $display("FAIL conflict_bypass: got %h expected 12345678", rd_data[0]); end
`else
      vectors++;
      if (rd_data[0] !== 32'h0) begin miscompares++; $display("FAIL conflict_old: got %h expected 0", rd_data[0]); end
`endif
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++;
      if (rd_data[0] !== 32'h1234_5678) begin miscompares++; $display("FAIL conflict_r5: got %h expected 12345678", rd_data[0]); end
      vectors++;
      if (wr_conflict !== 1'b0) begin miscompares++; $display("FAIL conflict_clear: got %b expected 0", wr_conflict); end
      // different addresses: no conflict
      wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd6;
      #1;
      vectors++;
      if (wr_conflict !== 1'b0) begin miscompares++; $display("FAIL conflict_diff: got %b expected 0", wr_conflict); end
      // both ports to r0: not a conflict
      wr_addr[0] = 5'd0; wr_addr[1] = 5'd0;
      #1;
      vectors++;
      if (wr_conflict !== 1'b0) begin miscompares++; $display("FAIL conflict_r0: got %b expected 0", wr_conflict); end
      // only one enabled: no conflict
      wr_en = 2'b10; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
      #1;
      vectors++;
      if (wr_conflict !== 1'b0) begin miscompares++; $display("FAIL conflict_single: got %b expected 0", wr_conflict); end
      clear_inputs();
   endtask

   task automatic test_r0();
      @(negedge clk);
      wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
      rd_addr[0] = 5'd0;
      @(negedge clk);
      clear_inputs();
      iss_en = 1'b1; iss_addr = 5'd0;
      #1;
      vectors++;
      if (rd_data[0] !== 32'h0) begin miscompares++; $display("FAIL r0_data: got %h expected 0", rd_data[0]); end
      vectors++;
      if (iss_ok !== 1'b1) begin miscompares++; $display("FAIL r0_iss_ok: got %b expected 1", iss_ok); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++;
      if (rd_busy[0] !== 1'b0) begin miscompares++; $display("FAIL r0_busy: got %b expected 0", rd_busy[0]); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 5'd7; rd_addr[1] = 5'd7;
      #1;
      vectors++;
      if (iss_ok !== 1'b1) begin miscompares++; $display("FAIL sb_first_iss: got %b expected 1", iss_ok); end
      @(negedge clk);
      #1;
      vectors++;
      if (iss_ok !== 1'b0) begin miscompares++; $display("FAIL sb_reissue: got %b expected 0", iss_ok); end
      vectors++;
      if (rd_busy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_busy_set: got %b expected 1", rd_busy[1]); end
      @(negedge clk);
      iss_en = 1'b0;
      #1;
      vectors++;
      if (rd_busy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_busy_hold: got %b expected 1", rd_busy[1]); end
      wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h0000_00A5;
      #1;
`ifdef RF_BYPASS_EN
      vectors++;
      if (rd_busy[1] !== 1'b0) begin miscompares++; $display("FAIL sb_busy_bypass: got %b expected 0", rd_busy[1]); end
`else
      vectors++;
      if (rd_busy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_busy_nobypass: got %b expected 1", rd_busy[1]); end
`endif
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++;
      if (rd_busy[1] !== 1'b0) begin miscompares++; $display("FAIL sb_busy_cleared: got %b expected 0", rd_busy[1]); end
      vectors++;
      if (rd_data[1] !== 32'h0000_00A5) begin miscompares++; $display("FAIL sb_r7_data: got %h expected a5", rd_data[1]); end
      // take ownership again, then re-issue while a writeback lands
      iss_en = 1'b1; iss_addr = 5'd7;
      @(negedge clk);
      wr_en = 2'b10; wr_addr[1] = 5'd7; wr_data[1] = 32'h0000_005A;
      #1;
      vectors++;
      if (iss_ok !== 1'b1) begin miscompares++; $display("FAIL sb_iss_with_wr: got %b expected 1", iss_ok); end
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++;
      if (rd_busy[1] !== 1'b1) begin miscompares++; $display("FAIL sb_new_owner: got %b expected 1", rd_busy[1]); end
      vectors++;
      if (rd_data[1] !== 32'h0000_005A) begin miscompares++; $display("FAIL sb_r7_new: got %h expected 5a", rd_data[1]); end
      // release r7
      wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h0000_005A;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h0000_0011;
      @(negedge clk);
      wr_data[0] = 32'h0000_0055; rd_addr[0] = 5'd3;
      #1;
`ifdef RF_BYPASS_EN
      vectors++;
      if (rd_data[0] !== 32'h55) begin miscompares++; $display("FAIL byp_same: got %h expected 55", rd_data[0]); end
`else
      vectors++;
      if (rd_data[0] !== 32'h11) begin miscompares++; $display("FAIL byp_old: got %h expected 11", rd_data[0]); end
`endif
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++;
      if (rd_data[0] !== 32'h55) begin miscompares++; $display("FAIL byp_next: got %h expected 55", rd_data[0]); end
      wr_en = 2'b11;
      wr_addr[0] = 5'd3; wr_data[0] = 32'h66;
      wr_addr[1] = 5'd3; wr_data[1] = 32'h77;
      #1;
`ifdef RF_BYPASS_EN
      vectors++;
      if (rd_data[0] !== 32'h77) begin miscompares++; $display("FAIL byp_prio: got %h expected 77", rd_data[0]); end
`else
      vectors++;
      if (rd_data[0] !== 32'h55) begin miscompares++; $display("FAIL byp_prio_old: got %h expected 55", rd_data[0]); end
`endif
      @(negedge clk);
      clear_inputs();
      #1;
      vectors++;
      if (rd_data[0] !== 32'h77) begin miscompares++; $display("FAIL byp_prio_next: got %h expected 77", rd_data[0]); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         wr_en = 2'b11;
         wr_addr[0] = AW'(2 * k + 10); wr_data[0] = 32'h1000_0000 + 32'(2 * k + 10) * 32'h111;
         wr_addr[1] = AW'(2 * k + 11); wr_data[1] = 32'h1000_0000 + 32'(2 * k + 11) * 32'h111;
      end
      @(negedge clk);
      clear_inputs();
      for (int a = 10; a < 18; a++) begin
         rd_addr[0] = AW'(a);
         rd_addr[1] = AW'(a);
         #1;
         vectors++;
         if (rd_data[0] !== 32'h1000_0000 + 32'(a) * 32'h111 || rd_data[1] !== rd_data[0]) begin
            miscompares++;
            $display("FAIL b2b r%0d: got %h/%h expected %h", a, rd_data[0], rd_data[1],
                     32'h1000_0000 + 32'(a) * 32'h111);
         end
      end
   endtask

   task automatic test_reset_async();
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 5'd9;
      wr_en = 2'b01; wr_addr[0] = 5'd10; wr_data[0] = 32'h0000_CAFE;
      @(negedge clk);
      clear_inputs();
      rd_addr[0] = 5'd9; rd_addr[1] = 5'd10;
      #1;
      vectors++;
      if (rd_busy[0] !== 1'b1) begin miscompares++; $display("FAIL arst_pre_busy: got %b expected 1", rd_busy[0]); end
      vectors++;
      if (rd_data[1] !== 32'h0000_CAFE) begin miscompares++; $display("FAIL arst_pre_data: got %h expected cafe", rd_data[1]); end
      #1;
      rst = 1'b1;
      #1;
      vectors++;
      if (rd_busy[0] !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b expected 0", rd_busy[0]); end
      vectors++;
      if (rd_data[1] !== 32'h0) begin miscompares++; $display("FAIL arst_r10: got %h expected 0", rd_data[1]); end
      rd_addr[1] = 5'd3;
      #1;
      vectors++;
      if (rd_data[1] !== 32'h0) begin miscompares++; $display("FAIL arst_r3: got %h expected 0", rd_data[1]); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      rd_addr = '0;
      test_reset();
      test_conflict();
      test_r0();
      test_scoreboard();
      test_bypass();
      test_back_to_back();
      test_reset_async();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_sb_reg_file

// File: doc/sb_reg_file.md
SB_REG_FILE -- requirements
Module: sb_reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per register.
REQ-002 Parameter ADDR_WIDTH, default 5, address bits; depth = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_RD, default 2, read ports (1..4).
REQ-004 Parameter NUM_WR, default 2, write ports (1..4).
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_en  input  NUM_WR  per-port write strobe.
REQ-008 wr_addr  input  NUM_WR x ADDR_WIDTH  per-port write address.
REQ-009 wr_data  input  NUM_WR x DATA_WIDTH  per-port write data.
REQ-010 rd_addr  input  NUM_RD x ADDR_WIDTH  per-port read address.
REQ-011 rd_data  output  NUM_RD x DATA_WIDTH  per-port read data, combinational.
REQ-012 rd_busy  output  NUM_RD  scoreboard busy bit of addressed register.
REQ-013 iss_en  input  1  issue request: mark iss_addr busy (pending writeback).
REQ-014 iss_addr  input  ADDR_WIDTH  destination register of issue.
REQ-015 iss_ok  output  1  issue accepted this cycle, combinational.
REQ-016 wr_conflict  output  1  two or more enabled write ports target same nonzero address this cycle.

Function
REQ-017 Register 0 SHALL read 0, never be written, never be busy; issue to 0 SHALL give iss_ok=1 with no state change.
REQ-018 Each enabled write port to nonzero address SHALL update the register at next rising edge.
REQ-019 Same-address multi-port writes SHALL resolve to highest-index port; wr_conflict=1 that cycle.
REQ-020 Busy bit SHALL clear at the edge of any enabled write to that register.
REQ-021 iss_ok SHALL be 1 when iss_en=1 and (iss_addr==0 or busy[iss_addr]==0 or a write to iss_addr occurs this cycle); else 0.
REQ-022 Accepted issue SHALL set busy[iss_addr] at next edge; set wins over same-cycle write clear (new owner).
REQ-023 Rejected issue (iss_ok=0) SHALL leave state unchanged; requester retries.
REQ-024 rd_data/rd_busy SHALL be pure functions of current state (plus bypass, REQ-029) with zero-cycle latency.
REQ-025 Out-of-range parameters SHALL not be supported; no runtime checks required.

Reset
REQ-026 Assertion of rst SHALL immediately zero all registers and busy bits regardless of clk.
REQ-027 During and after reset until first write: rd_data=0, rd_busy=0, wr_conflict=0, iss_ok=iss_en.
REQ-028 Writes/issues coincident with rst SHALL be discarded.

Configuration
REQ-029 Macro RF_BYPASS_EN defined: rd_data SHALL return same-cycle write data (highest-index matching port) and rd_busy SHALL read 0 when a write to the addressed register is active; undefined: rd_data/rd_busy reflect stored state only, write visible next cycle.

Structure
REQ-030 Package sb_reg_file_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and a write-port struct (en, addr, data).
REQ-031 Sub-module rf_scoreboard SHALL own busy bits, iss_ok and clear/set priority; data array and read muxing remain in sb_reg_file.

Verification
REQ-032 Reset then read all addresses on both ports -> rd_data=0, rd_busy=0.
REQ-033 Port0 writes 0xDEADBEEF to r5, port1 writes 0x12345678 to r5 same cycle -> wr_conflict=1; next cycle r5=0x12345678.
REQ-034 Write 0xFFFFFFFF to r0 -> r0 reads 0; issue r0 -> iss_ok=1, rd_busy(r0)=0.
REQ-035 Issue r7; next cycle issue r7 -> iss_ok=0; write r7=0xA5 -> busy clears; same-cycle re-issue r7 -> iss_ok=1, busy=1 after edge.
REQ-036 With RF_BYPASS_EN, write r3=0x55 and read r3 same cycle -> rd_data=0x55; without macro -> old value, 0x55 next cycle.
REQ-037 Issue r9, assert rst mid-cycle -> busy(r9)=0 and all registers 0 immediately.
